// File: rtl/handshake_monitor_pkg.sv
// Shared types for the valid/ready handshake monitor.
// The channel FSM tracks whether an offered beat is still waiting for ready.
package handshake_monitor_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } hs_state_e;

endpackage : handshake_monitor_pkg

// File: rtl/handshake_monitor_chan.sv
// One monitored valid/ready channel: handshake/stall counters, sticky protocol
// violation flags, and a circular history of the last HistDepth accepted beats.
module handshake_monitor_chan
   import handshake_monitor_pkg::*;
#(
   parameter type         T         = logic,
   parameter int unsigned CntWidth  = 32,
   parameter int unsigned HistDepth = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic                         valid_i,
   input  logic                         ready_i,
   input  T                             data_i,
   input  logic [$clog2(HistDepth)-1:0] hist_idx_i,
   output logic                         hs_o,
   output T                             wave_o,
   output logic [CntWidth-1:0]          beat_cnt_o,
   output logic [CntWidth-1:0]          stall_cnt_o,
   output logic                         valid_drop_o,
   output logic                         data_unstable_o,
   output T                             hist_data_o,
   output logic [$clog2(HistDepth):0]   hist_cnt_o,
   output hs_state_e                    state_o
);

   localparam int unsigned AW  = $clog2(HistDepth);
   localparam int unsigned HCW = AW + 1;

   hs_state_e           state_q,    state_d;
   T                    hold_q,     hold_d;
   logic [CntWidth-1:0] beat_q,     beat_d;
   logic [CntWidth-1:0] stall_q,    stall_d;
   logic                drop_q,     drop_d;
   logic                unstable_q, unstable_d;
   logic [AW-1:0]       wptr_q,     wptr_d;
   logic [HCW-1:0]      hcnt_q,     hcnt_d;
   T                    hist_q [HistDepth];
   T                    hist_d [HistDepth];

   logic          hs;
   logic          stall_cyc;
   logic [AW-1:0] rd_ptr;

   assign hs        = valid_i & ready_i;
   assign stall_cyc = valid_i & ~ready_i;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      beat_d     = beat_q;
      stall_d    = stall_q;
      drop_d     = drop_q;
      unstable_d = unstable_q;
      wptr_d     = wptr_q;
      hcnt_d     = hcnt_q;
      hist_d     = hist_q;

      case (state_q)
         ST_IDLE: begin
            if (stall_cyc) begin
               state_d = ST_STALL;
               hold_d  = data_i;
            end
         end
         ST_STALL: begin
            // The offered payload must stay frozen until accepted, including the accepting cycle.
            if (valid_i && (data_i != hold_q)) unstable_d = 1'b1;
            if (!valid_i && !ready_i)          drop_d     = 1'b1;
            if (!valid_i || ready_i)           state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (hs && (beat_q != '1))         beat_d  = beat_q + CntWidth'(1);
      if (stall_cyc && (stall_q != '1)) stall_d = stall_q + CntWidth'(1);

      if (hs) begin
         hist_d[wptr_q] = data_i;
         wptr_d         = wptr_q + AW'(1);
         if (hcnt_q != HCW'(HistDepth)) hcnt_d = hcnt_q + HCW'(1);
      end

      // Clear overrides everything above, including a coincident handshake.
      if (clear_i) begin
         state_d    = ST_IDLE;
         hold_d     = '0;
         beat_d     = '0;
         stall_d    = '0;
         drop_d     = 1'b0;
         unstable_d = 1'b0;
         wptr_d     = '0;
         hcnt_d     = '0;
         for (int i = 0; i < int'(HistDepth); i++) hist_d[i] = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         hold_q     <= '0;
         beat_q     <= '0;
         stall_q    <= '0;
         drop_q     <= 1'b0;
         unstable_q <= 1'b0;
         wptr_q     <= '0;
         hcnt_q     <= '0;
         for (int i = 0; i < int'(HistDepth); i++) hist_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         beat_q     <= beat_d;
         stall_q    <= stall_d;
         drop_q     <= drop_d;
         unstable_q <= unstable_d;
         wptr_q     <= wptr_d;
         hcnt_q     <= hcnt_d;
         hist_q     <= hist_d;
      end
   end

   // Most recent beat sits one slot behind the write pointer.
   assign rd_ptr = wptr_q - AW'(1) - hist_idx_i;

   always_comb begin
      hist_data_o = '0;
      if ({1'b0, hist_idx_i} < hcnt_q) hist_data_o = hist_q[rd_ptr];
   end

   assign hs_o            = hs;
   assign wave_o          = hs ? data_i : T'('0);
   assign beat_cnt_o      = beat_q;
   assign stall_cnt_o     = stall_q;
   assign valid_drop_o    = drop_q;
   assign data_unstable_o = unstable_q;
   assign hist_cnt_o      = hcnt_q;
   assign state_o         = state_q;

endmodule : handshake_monitor_chan

// File: rtl/handshake_monitor.sv
// Passive monitor for NumChannels independent valid/ready links; each channel
// is an independent handshake_monitor_chan sharing only clock, reset and clear.
module handshake_monitor
   import handshake_monitor_pkg::*;
#(
   parameter int unsigned NumChannels = 1,
   parameter type         T           = logic,
   parameter int unsigned CntWidth    = 32,
   parameter int unsigned HistDepth   = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic [NumChannels-1:0]       valid_i,
   input  logic [NumChannels-1:0]       ready_i,
   input  T                             data_i          [NumChannels],
   input  logic [$clog2(HistDepth)-1:0] hist_idx_i,
   output logic [NumChannels-1:0]       hs_o,
   output T                             wave_o          [NumChannels],
   output logic [CntWidth-1:0]          beat_cnt_o      [NumChannels],
   output logic [CntWidth-1:0]          stall_cnt_o     [NumChannels],
   output logic [NumChannels-1:0]       valid_drop_o,
   output logic [NumChannels-1:0]       data_unstable_o,
   output T                             hist_data_o     [NumChannels],
   output logic [$clog2(HistDepth):0]   hist_cnt_o      [NumChannels],
   output hs_state_e                    state_o         [NumChannels]
);

   // Handshake rule: a beat transfers on every rising edge where valid_i and
   // ready_i are both high; once valid_i rises it must stay high with stable
   // data_i until that transfer, and ready_i may toggle freely.
   for (genvar g = 0; g < int'(NumChannels); g++) begin : g_chan
      handshake_monitor_chan #(
         .T         (T),
         .CntWidth  (CntWidth),
         .HistDepth (HistDepth)
      ) u_chan (
         .clk_i           (clk_i),
         .rst_i           (rst_i),
         .clear_i         (clear_i),
         .valid_i         (valid_i[g]),
         .ready_i         (ready_i[g]),
         .data_i          (data_i[g]),
         .hist_idx_i      (hist_idx_i),
         .hs_o            (hs_o[g]),
         .wave_o          (wave_o[g]),
         .beat_cnt_o      (beat_cnt_o[g]),
         .stall_cnt_o     (stall_cnt_o[g]),
         .valid_drop_o    (valid_drop_o[g]),
         .data_unstable_o (data_unstable_o[g]),
         .hist_data_o     (hist_data_o[g]),
         .hist_cnt_o      (hist_cnt_o[g]),
         .state_o         (state_o[g])
      );
   end

endmodule : handshake_monitor

// File: doc/handshake_monitor.md
HANDSHAKE_MONITOR -- requirements
Module: handshake_monitor

Interface
REQ-001 SHALL have parameter NumChannels, default 1, number of independent valid/ready channels monitored.
REQ-002 SHALL have parameter type T, default logic, payload type of every channel.
REQ-003 SHALL have parameter CntWidth, default 32, width of beat and stall counters.
REQ-004 SHALL have parameter HistDepth, default 4, power of two >=2, beats retained per channel.
REQ-005 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port clear_i, input, 1, synchronous clear of all counters, flags, history and FSMs.
REQ-008 SHALL have ports valid_i / ready_i, input, NumChannels, observed handshake per channel.
REQ-009 SHALL have port data_i, input, NumChannels x T, observed payload per channel.
REQ-010 SHALL have port hs_o, output, NumChannels, combinational valid_i & ready_i.
REQ-011 SHALL have port wave_o, output, NumChannels x T, data_i when hs_o set, else all '0.
REQ-012 SHALL have ports beat_cnt_o / stall_cnt_o, output, NumChannels x CntWidth, handshake count / cycles with valid high and ready low.
REQ-013 SHALL have ports valid_drop_o / data_unstable_o, output, NumChannels, sticky protocol-violation flags.
REQ-014 SHALL have port hist_idx_i, input, $clog2(HistDepth), 0 = most recent beat.
REQ-015 SHALL have ports hist_data_o (NumChannels x T) / hist_cnt_o (NumChannels x ($clog2(HistDepth)+1)), output, history read and valid-entry count.

Function
REQ-016 Per-channel FSM SHALL have states IDLE and STALL; reset and clear state IDLE.
REQ-017 IDLE -> STALL when valid_i=1, ready_i=0; data_i captured into a hold register the same edge.
REQ-018 STALL -> IDLE on handshake (valid_i=1, ready_i=1) or on valid_i=0.
REQ-019 In STALL, valid_i=0 with ready_i=0 SHALL set valid_drop_o the next cycle.
REQ-020 In STALL, valid_i=1 with data_i != hold register SHALL set data_unstable_o the next cycle, also on the handshake cycle.
REQ-021 Violation flags SHALL stay set until rst_i or clear_i.
REQ-022 beat_cnt_o SHALL increment by 1 each handshake cycle and be visible one cycle later.
REQ-023 stall_cnt_o SHALL increment by 1 each cycle with valid_i=1, ready_i=0.
REQ-024 Both counters SHALL saturate at 2^CntWidth-1 with no wrap.
REQ-025 Each handshake SHALL write data_i into a per-channel circular buffer with HistDepth entries. The write pointer wraps modulo HistDepth, and the oldest entry is overwritten when the buffer is full.
REQ-026 hist_cnt_o SHALL increment per handshake and saturate at HistDepth.
REQ-027 hist_data_o SHALL be combinational: the entry written hist_idx_i handshakes before the latest one.
REQ-028 hist_data_o SHALL be '0 when hist_idx_i >= hist_cnt_o.
REQ-029 When clear_i coincides with a handshake, clear SHALL win: all state is zero/IDLE next cycle and the beat is not recorded.
REQ-030 Channels SHALL be fully independent; simultaneous handshakes on all channels SHALL all be recorded.
REQ-031 hs_o and wave_o SHALL have zero latency and SHALL NOT depend on registered state.

Reset
REQ-032 With rst_i asserted, all of the following SHALL be zero asynchronously: counters, flags, hist_cnt_o, write pointers, hold registers and history storage. FSMs SHALL be in IDLE.
REQ-033 Reset asserted mid-stall SHALL discard the stall without setting any violation flag.
REQ-034 After rst_i deasserts, the first edge SHALL already count and record normally.

Structure
REQ-035 The FSM state enum (IDLE, STALL) SHALL live in handshake_monitor_pkg.
REQ-036 Per-channel logic SHALL be the sub-module handshake_monitor_chan, instantiated NumChannels times through a generate loop.

Verification
REQ-037 Channel 0, 3 handshakes with data 0xA, 0xB, 0xC -> beat_cnt_o=3, hist_cnt_o=3, hist idx0=0xC, idx2=0xA, idx3='0.
REQ-038 valid_i=1, ready_i=0 for 5 cycles, then ready_i=1 with data constant -> stall_cnt_o=5, beat_cnt_o=1, no flags set.
REQ-039 Stall with data 0x5, then data changes to 0x6 while still stalled -> data_unstable_o=1 next cycle and still 1 after 10 idle cycles.
REQ-040 Stall, then valid_i drops with ready_i=0 -> valid_drop_o=1, FSM back in IDLE, beat_cnt_o unchanged.
REQ-041 HistDepth=4, 6 handshakes of 1..6 -> hist_cnt_o=4, idx0=6, idx3=3.
REQ-042 Handshake coincident with clear_i, and separately rst_i pulsed mid-stall -> all outputs except hs_o/wave_o are zero next cycle.
